// File: rtl/phase_sequencer.sv
// Machine-cycle phase sequencer: steps FETCH..WB on divider ticks, with run/step/halt/wait control.
// Optional PHASE_SEQ_SKIP_MEM_EN adds i_no_mem to bypass MEM from EXEC.
module phase_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_halt_req,
    input  logic             i_clr_halt,
    input  logic             i_wait,
`ifdef PHASE_SEQ_SKIP_MEM_EN
    input  logic             i_no_mem,
`endif
    output logic [2:0]       o_phase,
    output logic             o_ph_stb,
    output logic             o_retire,
    output logic [CNT_W-1:0] o_instr_cnt,
    output logic             o_busy,
    output logic             o_halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } phase_e;

    phase_e           r_state;
    phase_e           w_next;
    logic             r_step_pend;
    logic             r_halt_pend;
    logic             r_ph_stb;
    logic             r_retire;
    logic             r_busy;
    logic             r_halted;
    logic [CNT_W-1:0] r_cnt;
    logic             w_halt_any;
    logic             w_chg;
    logic             w_retire;
    logic             w_busy;
    logic             w_halted;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_step_pend <= 1'b0;
            r_halt_pend <= 1'b0;
            r_ph_stb    <= 1'b0;
            r_retire    <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state  <= w_next;
            r_ph_stb <= w_chg;
            r_retire <= w_retire;
            r_busy   <= w_busy;
            r_halted <= w_halted;
            if (w_retire)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_next == S_FETCH && r_state != S_FETCH)
                r_step_pend <= 1'b0;
            else if (r_state == S_IDLE && i_step)
                r_step_pend <= 1'b1;
            if (w_next == S_HALT)
                r_halt_pend <= 1'b0;
            else if (i_halt_req && r_state != S_HALT)
                r_halt_pend <= 1'b1;
        end
    end

    // A halt request arriving on the boundary edge itself is honoured at that edge.
    always_comb begin
        w_halt_any = r_halt_pend | i_halt_req;
        w_next     = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_tick) begin
                    if (w_halt_any)
                        w_next = S_HALT;
                    else if (i_run || r_step_pend)
                        w_next = S_FETCH;
                end
            end
            S_FETCH:  if (i_tick) w_next = S_DECODE;
            S_DECODE: if (i_tick) w_next = S_EXEC;
            S_EXEC: begin
                if (i_tick) begin
`ifdef PHASE_SEQ_SKIP_MEM_EN
                    w_next = i_no_mem ? S_WB : S_MEM;
`else
                    w_next = S_MEM;
`endif
                end
            end
            S_MEM: if (i_tick && !i_wait) w_next = S_WB;
            S_WB: begin
                if (i_tick) begin
                    if (w_halt_any)
                        w_next = S_HALT;
                    else if (i_run)
                        w_next = S_FETCH;
                    else
                        w_next = S_IDLE;
                end
            end
            S_HALT: if (i_clr_halt && !i_halt_req) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_chg    = (w_next != r_state);
        w_retire = (r_state == S_WB) && i_tick;
        w_busy   = (w_next != S_IDLE) && (w_next != S_HALT);
        w_halted = (w_next == S_HALT);
    end

    assign o_phase     = r_state;
    assign o_ph_stb    = r_ph_stb;
    assign o_retire    = r_retire;
    assign o_instr_cnt = r_cnt;
    assign o_busy      = r_busy;
    assign o_halted    = r_halted;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer; a second instance with CNT_W=2 checks counter wrap.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        halt_req = 1'b0;
    logic        clr_halt = 1'b0;
    logic        mwait = 1'b0;
`ifdef PHASE_SEQ_SKIP_MEM_EN
    logic        no_mem = 1'b0;
`endif
    logic [2:0]  phase, phase2;
    logic        ph_stb, ph_stb2;
    logic        retire, retire2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic        busy, busy2;
    logic        halted, halted2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    phase_sequencer #(.CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_run(run), .i_step(step),
        .i_halt_req(halt_req), .i_clr_halt(clr_halt), .i_wait(mwait),
`ifdef PHASE_SEQ_SKIP_MEM_EN
        .i_no_mem(no_mem),
`endif
        .o_phase(phase), .o_ph_stb(ph_stb), .o_retire(retire), .o_instr_cnt(cnt),
        .o_busy(busy), .o_halted(halted)
    );

    phase_sequencer #(.CNT_W(2)) u_dut_w2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_run(run), .i_step(step),
        .i_halt_req(halt_req), .i_clr_halt(clr_halt), .i_wait(mwait),
`ifdef PHASE_SEQ_SKIP_MEM_EN
        .i_no_mem(no_mem),
`endif
        .o_phase(phase2), .o_ph_stb(ph_stb2), .o_retire(retire2), .o_instr_cnt(cnt2),
        .o_busy(busy2), .o_halted(halted2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tk();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick = 1'b0; run = 1'b0; step = 1'b0;
        halt_req = 1'b0; clr_halt = 1'b0; mwait = 1'b0;
`ifdef PHASE_SEQ_SKIP_MEM_EN
        no_mem = 1'b0;
`endif
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic drain();
        run = 1'b0;
        for (int i = 0; i < 12 && phase !== 3'd0; i++) tk();
        checks++;
        if (phase !== 3'd0) begin
            failures++;
            $display("FAIL drain_to_idle phase=%0d expected=0", phase);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; tick = 1'b1;
        repeat (3) cyc();
        checks++;
        if (phase !== 3'd0 || ph_stb !== 1'b0 || retire !== 1'b0) begin
            failures++;
            $display("FAIL reset_phase phase=%0d stb=%b ret=%b expected 0/0/0", phase, ph_stb, retire);
        end
        checks++;
        if (cnt !== 16'd0 || busy !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_misc cnt=%0d busy=%b halted=%b expected 0/0/0", cnt, busy, halted);
        end
        tick = 1'b0; run = 1'b0; rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_free_run();
        logic [2:0] exp_ph;
        logic [2:0] prev;
        int nret;
        int last_ret;
        do_reset();
        run = 1'b1; exp_ph = 3'd0; nret = 0; last_ret = 0;
        for (int k = 1; k <= 16; k++) begin
            repeat (3) begin
                cyc();
                checks++;
                if (ph_stb !== 1'b0 || retire !== 1'b0) begin
                    failures++;
                    $display("FAIL run_gap tick=%0d stb=%b ret=%b expected 0/0", k, ph_stb, retire);
                end
            end
            prev = exp_ph;
            exp_ph = (exp_ph == 3'd5) ? 3'd1 : exp_ph + 3'd1;
            tk();
            checks++;
            if (phase !== exp_ph || ph_stb !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL run_phase tick=%0d phase=%0d stb=%b busy=%b expected %0d/1/1", k, phase, ph_stb, busy, exp_ph);
            end
            checks++;
            if (retire !== (prev == 3'd5)) begin
                failures++;
                $display("FAIL run_retire tick=%0d retire=%b expected %b", k, retire, prev == 3'd5);
            end
            checks++;
            if ({phase2, ph_stb2, retire2, busy2, halted2} !== {exp_ph, 1'b1, prev == 3'd5, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL w2_track tick=%0d phase=%0d expected %0d", k, phase2, exp_ph);
            end
            if (retire === 1'b1) begin
                nret++;
                checks++;
                if (cnt !== 16'(nret) || cnt2 !== 2'(nret)) begin
                    failures++;
                    $display("FAIL run_cnt tick=%0d cnt=%0d cnt2=%0d expected %0d/%0d", k, cnt, cnt2, nret, nret % 4);
                end
                if (last_ret != 0) begin
                    checks++;
                    if ((k - last_ret) * 4 != 20) begin
                        failures++;
                        $display("FAIL retire_spacing clk=%0d expected=20", (k - last_ret) * 4);
                    end
                end
                last_ret = k;
            end
        end
        checks++;
        if (nret != 3 || cnt !== 16'd3) begin
            failures++;
            $display("FAIL run_total retires=%0d cnt=%0d expected 3/3", nret, cnt);
        end
        drain();
        checks++;
        if (cnt !== 16'd4 || cnt2 !== 2'd0) begin
            failures++;
            $display("FAIL cnt2_wrap cnt=%0d cnt2=%0d expected 4/0", cnt, cnt2);
        end
    endtask

    task automatic test_step();
        logic [2:0] seq [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0};
        int nret;
        do_reset();
        nret = 0;
        step = 1'b1;
        cyc();
        step = 1'b0;
        checks++;
        if (phase !== 3'd0) begin
            failures++;
            $display("FAIL step_no_tick phase=%0d expected=0", phase);
        end
        tick = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step = (i == 3);
            cyc();
            step = 1'b0;
            if (retire === 1'b1) nret++;
            checks++;
            if (phase !== seq[i] || retire !== (i == 5) || ph_stb !== (i < 6)) begin
                failures++;
                $display("FAIL step_seq i=%0d phase=%0d ret=%b stb=%b expected %0d/%b/%b", i, phase, retire, ph_stb, seq[i], i == 5, i < 6);
            end
        end
        tick = 1'b0;
        checks++;
        if (nret != 1 || cnt !== 16'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL step_total retires=%0d cnt=%0d busy=%b expected 1/1/0", nret, cnt, busy);
        end
    endtask

    task automatic test_wait();
        do_reset();
        run = 1'b1;
        repeat (4) tk();
        checks++;
        if (phase !== 3'd4) begin
            failures++;
            $display("FAIL wait_reach_mem phase=%0d expected=4", phase);
        end
        mwait = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tk();
            checks++;
            if (phase !== 3'd4 || ph_stb !== 1'b0) begin
                failures++;
                $display("FAIL wait_hold i=%0d phase=%0d stb=%b expected 4/0", i, phase, ph_stb);
            end
        end
        mwait = 1'b0;
        cyc();
        mwait = 1'b1;
        tk();
        checks++;
        if (phase !== 3'd4 || ph_stb !== 1'b0) begin
            failures++;
            $display("FAIL wait_sampled_on_tick phase=%0d stb=%b expected 4/0", phase, ph_stb);
        end
        mwait = 1'b0;
        tk();
        checks++;
        if (phase !== 3'd5 || ph_stb !== 1'b1) begin
            failures++;
            $display("FAIL wait_release phase=%0d stb=%b expected 5/1", phase, ph_stb);
        end
        tk();
        checks++;
        if (phase !== 3'd1 || retire !== 1'b1 || cnt !== 16'd1) begin
            failures++;
            $display("FAIL wait_retire phase=%0d ret=%b cnt=%0d expected 1/1/1", phase, retire, cnt);
        end
        drain();
    endtask

    task automatic test_halt();
        do_reset();
        run = 1'b1;
        tk(); tk();
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        checks++;
        if (phase !== 3'd2) begin
            failures++;
            $display("FAIL halt_req_no_tick phase=%0d expected=2", phase);
        end
        tk(); tk(); tk();
        checks++;
        if (phase !== 3'd5) begin
            failures++;
            $display("FAIL halt_completes phase=%0d expected=5", phase);
        end
        tk();
        checks++;
        if (phase !== 3'd7 || retire !== 1'b1 || halted !== 1'b1 || busy !== 1'b0 || ph_stb !== 1'b1) begin
            failures++;
            $display("FAIL halt_enter phase=%0d ret=%b halted=%b busy=%b stb=%b expected 7/1/1/0/1", phase, retire, halted, busy, ph_stb);
        end
        for (int i = 0; i < 3; i++) begin
            tk();
            checks++;
            if (phase !== 3'd7 || ph_stb !== 1'b0) begin
                failures++;
                $display("FAIL halt_sticky i=%0d phase=%0d stb=%b expected 7/0", i, phase, ph_stb);
            end
        end
        halt_req = 1'b1; clr_halt = 1'b1;
        cyc();
        halt_req = 1'b0; clr_halt = 1'b0;
        checks++;
        if (phase !== 3'd7) begin
            failures++;
            $display("FAIL halt_req_and_clr phase=%0d expected=7", phase);
        end
        clr_halt = 1'b1;
        cyc();
        clr_halt = 1'b0;
        checks++;
        if (phase !== 3'd0 || ph_stb !== 1'b1 || halted !== 1'b0) begin
            failures++;
            $display("FAIL clr_halt phase=%0d stb=%b halted=%b expected 0/1/0", phase, ph_stb, halted);
        end
        tk();
        checks++;
        if (phase !== 3'd1) begin
            failures++;
            $display("FAIL after_clr_tick phase=%0d expected=1", phase);
        end
        drain();
        tk();
        checks++;
        if (phase !== 3'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_pend_cleared phase=%0d halted=%b expected 0/0", phase, halted);
        end
    endtask

    task automatic test_halt_at_wb_exit();
        do_reset();
        run = 1'b1;
        repeat (5) tk();
        halt_req = 1'b1;
        tk();
        halt_req = 1'b0;
        checks++;
        if (phase !== 3'd7 || retire !== 1'b1 || cnt !== 16'd1) begin
            failures++;
            $display("FAIL halt_at_wb phase=%0d ret=%b cnt=%0d expected 7/1/1", phase, retire, cnt);
        end
        clr_halt = 1'b1;
        cyc();
        clr_halt = 1'b0;
        run = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        run = 1'b1;
        repeat (8) tk();
        checks++;
        if (phase !== 3'd3 || cnt !== 16'd1) begin
            failures++;
            $display("FAIL pre_reset phase=%0d cnt=%0d expected 3/1", phase, cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (phase !== 3'd0 || cnt !== 16'd0 || busy !== 1'b0 || ph_stb !== 1'b0 || retire !== 1'b0 || cnt2 !== 2'd0) begin
            failures++;
            $display("FAIL async_reset phase=%0d cnt=%0d busy=%b stb=%b ret=%b expected all 0", phase, cnt, busy, ph_stb, retire);
        end
        tick = 1'b1;
        repeat (3) begin
            cyc();
            checks++;
            if (retire !== 1'b0 || phase !== 3'd0) begin
                failures++;
                $display("FAIL reset_hold ret=%0b phase=%0d expected 0/0", retire, phase);
            end
        end
        tick = 1'b0; run = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_ph;
        int nret;
        do_reset();
        run = 1'b1; tick = 1'b1; exp_ph = 3'd0; nret = 0;
        for (int i = 0; i < 12; i++) begin
            exp_ph = (exp_ph == 3'd5) ? 3'd1 : exp_ph + 3'd1;
            cyc();
            if (retire === 1'b1) nret++;
            checks++;
            if (phase !== exp_ph || ph_stb !== 1'b1) begin
                failures++;
                $display("FAIL b2b_phase i=%0d phase=%0d stb=%b expected %0d/1", i, phase, ph_stb, exp_ph);
            end
        end
        tick = 1'b0;
        checks++;
        if (nret != 2 || cnt !== 16'd2) begin
            failures++;
            $display("FAIL b2b_total retires=%0d cnt=%0d expected 2/2", nret, cnt);
        end
        drain();
    endtask

`ifdef PHASE_SEQ_SKIP_MEM_EN
    task automatic test_skip_mem();
        logic [2:0] seq [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        do_reset();
        run = 1'b1; no_mem = 1'b1; tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (phase !== seq[i] || retire !== (i == 4)) begin
                failures++;
                $display("FAIL skip_mem i=%0d phase=%0d ret=%b expected %0d/%b", i, phase, retire, seq[i], i == 4);
            end
        end
        tick = 1'b0; no_mem = 1'b0;
        drain();
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_step();
        test_wait();
        test_halt();
        test_halt_at_wb_exit();
        test_reset_mid();
        test_back_to_back();
`ifdef PHASE_SEQ_SKIP_MEM_EN
        test_skip_mem();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
